seq_pattern_tx: RTL



---
 rtl/seq_pattern_tx_if.sv | 31 +++
 rtl/seq_pattern_tx.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_pattern_tx_if.sv
// Command/stream bundle for the serial pattern transmitter.
// master = controller issuing commands, slave = seq_pattern_tx itself.
interface seq_pattern_tx_if #(
    parameter int PAT_W = 8,
    parameter int LEN_W = 3,
    parameter int REP_W = 4,
    parameter int GAP_W = 4
);
    logic             ena;
    logic             start;
    logic             stop;
    logic [PAT_W-1:0] pattern;
    logic [LEN_W-1:0] len_m1;
    logic [REP_W-1:0] reps;
    logic [GAP_W-1:0] gap;
    logic             ser_out;
    logic             ser_valid;
    logic             busy;
    logic             done;
    logic [REP_W-1:0] rep_cnt;

    modport master (
        output ena, start, stop, pattern, len_m1, reps, gap,
        input  ser_out, ser_valid, busy, done, rep_cnt
    );

    modport slave (
        input  ena, start, stop, pattern, len_m1, reps, gap,
        output ser_out, ser_valid, busy, done, rep_cnt
    );
endinterface

// File: rtl/seq_pattern_tx.sv
// Serial bit-pattern transmitter: latches a pattern and shifts it MSB-first with repeats and gaps.
// Optional trailing even-parity bit per repetition when SEQ_PATTERN_TX_PARITY_EN is defined.
module seq_pattern_tx #(
    parameter int   PAT_W      = 8,
    parameter int   LEN_W      = 3,
    parameter int   REP_W      = 4,
    parameter int   GAP_W      = 4,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    seq_pattern_tx_if.slave  bus
);

`ifdef SEQ_PATTERN_TX_PARITY_EN
    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP, S_PARITY} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;
`endif

    state_t           r_state, w_state_next;
    logic [PAT_W-1:0] r_pat, w_pat_next;
    logic [LEN_W-1:0] r_len, w_len_next;
    logic [REP_W-1:0] r_reps, w_reps_next;
    logic [GAP_W-1:0] r_gap, w_gap_next;
    logic [LEN_W-1:0] r_idx, w_idx_next;
    logic [GAP_W-1:0] r_gap_cnt, w_gap_cnt_next;
    logic [REP_W-1:0] r_rep_cnt, w_rep_cnt_next;
    logic             r_ser_out, w_ser_out_next;
    logic             r_ser_valid, w_ser_valid_next;
    logic             r_busy, w_busy_next;
    logic             r_done, w_done_next;

    logic [LEN_W-1:0] w_len_clamp;
    logic [REP_W-1:0] w_rep_inc;
    logic             w_last_rep;
    logic             w_rep_end;

    // Bit select through a loop so any LEN_W/PAT_W pairing indexes safely.
    function automatic logic pick_bit(input logic [PAT_W-1:0] p, input logic [LEN_W-1:0] idx);
        logic b;
        b = 1'b0;
        for (int i = 0; i < PAT_W; i++) begin
            if (LEN_W'(i) == idx) b = p[i];
        end
        return b;
    endfunction

    assign w_len_clamp = (int'(bus.len_m1) >= PAT_W) ? LEN_W'(PAT_W - 1) : bus.len_m1;
    assign w_rep_inc   = r_rep_cnt + REP_W'(1);
    assign w_last_rep  = (r_reps != '0) && (w_rep_inc == r_reps);

`ifdef SEQ_PATTERN_TX_PARITY_EN
    logic [PAT_W-1:0] w_mask;
    logic             w_parity;

    generate
        for (genvar gi = 0; gi < PAT_W; gi++) begin : g_mask
            assign w_mask[gi] = (LEN_W'(gi) <= r_len);
        end
    endgenerate

    assign w_parity = ^(r_pat & w_mask);
`endif

    always_comb begin
        w_state_next     = r_state;
        w_pat_next       = r_pat;
        w_len_next       = r_len;
        w_reps_next      = r_reps;
        w_gap_next       = r_gap;
        w_idx_next       = r_idx;
        w_gap_cnt_next   = r_gap_cnt;
        w_rep_cnt_next   = r_rep_cnt;
        w_ser_out_next   = r_ser_out;
        w_ser_valid_next = r_ser_valid;
        w_busy_next      = r_busy;
        w_done_next      = 1'b0;
        w_rep_end        = 1'b0;

        if (bus.ena) begin
            if (bus.stop) begin
                // Abort wins everywhere, including over a simultaneous start.
                w_state_next     = S_IDLE;
                w_ser_out_next   = IDLE_LEVEL;
                w_ser_valid_next = 1'b0;
                w_busy_next      = 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (bus.start) begin
                            w_pat_next       = bus.pattern;
                            w_len_next       = w_len_clamp;
                            w_reps_next      = bus.reps;
                            w_gap_next       = bus.gap;
                            w_idx_next       = w_len_clamp;
                            w_rep_cnt_next   = '0;
                            w_state_next     = S_SHIFT;
                            w_ser_out_next   = pick_bit(bus.pattern, w_len_clamp);
                            w_ser_valid_next = 1'b1;
                            w_busy_next      = 1'b1;
                        end
                    end
                    S_SHIFT: begin
                        if (r_idx != '0) begin
                            w_idx_next     = r_idx - LEN_W'(1);
                            w_ser_out_next = pick_bit(r_pat, r_idx - LEN_W'(1));
                        end else begin
`ifdef SEQ_PATTERN_TX_PARITY_EN
                            w_state_next     = S_PARITY;
                            w_ser_out_next   = w_parity;
                            w_ser_valid_next = 1'b1;
`else
                            w_rep_end = 1'b1;
`endif
                        end
                    end
                    S_GAP: begin
                        if (r_gap_cnt <= GAP_W'(1)) begin
                            w_state_next     = S_SHIFT;
                            w_idx_next       = r_len;
                            w_ser_out_next   = pick_bit(r_pat, r_len);
                            w_ser_valid_next = 1'b1;
                        end else begin
                            w_gap_cnt_next = r_gap_cnt - GAP_W'(1);
                        end
                    end
`ifdef SEQ_PATTERN_TX_PARITY_EN
                    S_PARITY: begin
                        w_rep_end = 1'b1;
                    end
`endif
                    default: begin
                        w_state_next     = S_IDLE;
                        w_ser_out_next   = IDLE_LEVEL;
                        w_ser_valid_next = 1'b0;
                        w_busy_next      = 1'b0;
                    end
                endcase

                // End of a repetition: finish, insert a gap, or restart with no bubble.
                if (w_rep_end) begin
                    w_rep_cnt_next = w_rep_inc;
                    if (w_last_rep) begin
                        w_state_next     = S_IDLE;
                        w_ser_out_next   = IDLE_LEVEL;
                        w_ser_valid_next = 1'b0;
                        w_busy_next      = 1'b0;
                        w_done_next      = 1'b1;
                    end else if (r_gap != '0) begin
                        w_state_next     = S_GAP;
                        w_gap_cnt_next   = r_gap;
                        w_ser_out_next   = IDLE_LEVEL;
                        w_ser_valid_next = 1'b0;
                    end else begin
                        w_state_next     = S_SHIFT;
                        w_idx_next       = r_len;
                        w_ser_out_next   = pick_bit(r_pat, r_len);
                        w_ser_valid_next = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_pat       <= '0;
            r_len       <= '0;
            r_reps      <= '0;
            r_gap       <= '0;
            r_idx       <= '0;
            r_gap_cnt   <= '0;
            r_rep_cnt   <= '0;
            r_ser_out   <= IDLE_LEVEL;
            r_ser_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_pat       <= w_pat_next;
            r_len       <= w_len_next;
            r_reps      <= w_reps_next;
            r_gap       <= w_gap_next;
            r_idx       <= w_idx_next;
            r_gap_cnt   <= w_gap_cnt_next;
            r_rep_cnt   <= w_rep_cnt_next;
            r_ser_out   <= w_ser_out_next;
            r_ser_valid <= w_ser_valid_next;
            r_busy      <= w_busy_next;
            r_done      <= w_done_next;
        end
    end

    assign bus.ser_out   = r_ser_out;
    assign bus.ser_valid = r_ser_valid;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.rep_cnt   = r_rep_cnt;

endmodule
